// File: rtl/m68k_bus_pkg.sv
// ============================================================================
// Module  : m68k_bus_pkg
// Brief   : Shared 68000 bus definitions for the ROM, RAM and I/O bridges.
// Revision: 1.0
// ============================================================================
`default_nettype none

package m68k_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_e;

    // Active-low bus levels
    localparam logic C_BUS_ASSERT = 1'b0;
    localparam logic C_BUS_NEGATE = 1'b1;

    // Bit positions within a {upper, lower} byte-lane select
    localparam int C_LANE_UPPER = 1;
    localparam int C_LANE_LOWER = 0;

    function automatic logic [15:0] lane_mask(input logic [1:0] lanes,
                                              input logic [15:0] word);
        lane_mask = {lanes[C_LANE_UPPER] ? word[15:8] : 8'h00,
                     lanes[C_LANE_LOWER] ? word[7:0]  : 8'h00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_bus_bridge.sv
// ============================================================================
// Module  : rom_bus_bridge
// Brief   : 68000 bus slave for the synchronous program ROM. Define
//           ROM_BERR_EN to answer writes with BERR instead of DTACK.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_bus_bridge #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int LATENCY     = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  as_n,
    input  logic                  rw,
    input  logic                  uds_n,
    input  logic                  lds_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  dtack_n,
    output logic                  berr_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    import m68k_bus_pkg::*;

    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY + WAIT_STATES);

    bus_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  dtack_q, dtack_d;
`ifdef ROM_BERR_EN
    logic                  berr_q, berr_d;
`endif

    logic [1:0] w_lanes;
    logic       w_start;

    assign w_lanes = {~uds_n, ~lds_n};
    assign w_start = cs & ~as_n & (|w_lanes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            din_q   <= '0;
            dtack_q <= C_BUS_NEGATE;
`ifdef ROM_BERR_EN
            berr_q  <= C_BUS_NEGATE;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dtack_q <= dtack_d;
`ifdef ROM_BERR_EN
            berr_q  <= berr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dtack_d = dtack_q;
`ifdef ROM_BERR_EN
        berr_d  = berr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    if (rw) begin
                        addr_d  = cpu_addr;
                        cnt_d   = C_CNT_INIT;
                        state_d = ST_WAIT;
                    end else begin
`ifdef ROM_BERR_EN
                        berr_d  = C_BUS_ASSERT;
                        state_d = ST_ERR;
`else
                        dtack_d = C_BUS_ASSERT;
                        state_d = ST_ACK;
`endif
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // An early strobe release abandons the cycle without DTACK
                if (as_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    din_d   = DATA_WIDTH'(lane_mask(w_lanes, 16'(rom_dout)));
                    dtack_d = C_BUS_ASSERT;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (as_n) begin
                    dtack_d = C_BUS_NEGATE;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
`ifdef ROM_BERR_EN
                if (as_n) begin
                    berr_d  = C_BUS_NEGATE;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_din  = din_q;
    assign dtack_n  = dtack_q;
    assign rom_addr = addr_q;
`ifdef ROM_BERR_EN
    assign berr_n   = berr_q;
`else
    assign berr_n   = C_BUS_NEGATE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_bus_bridge.sv
// ============================================================================
// Module  : tb_rom_bus_bridge
// Brief   : Randomized self-checking bench for rom_bus_bridge; runs a default
//           instance and a LATENCY=2/WAIT_STATES=3 instance side by side.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_bus_bridge;

    localparam int AW  = 14;
    localparam int L_B = 2;
    localparam int W_B = 3;
    localparam int D_A = 1;          // start-to-DTACK cycles, default instance
    localparam int D_B = L_B + W_B;  // start-to-DTACK cycles, wait-state instance

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs = 1'b0, as_n = 1'b1, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
    logic [AW-1:0] cpu_addr = '0;

    logic [15:0]   din_a, din_b, rom_dout_a, rom_dout_b, rom_pipe_b;
    logic          dtack_a, dtack_b, berr_a, berr_b;
    logic [AW-1:0] raddr_a, raddr_b;

    logic [15:0]   rom_mem [0:(1<<AW)-1];

    logic [15:0]   e_din_a = '0, e_din_b = '0;
    logic [AW-1:0] e_addr_a = '0, e_addr_b = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rom_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .LATENCY(1), .WAIT_STATES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .cpu_addr(cpu_addr), .cpu_din(din_a), .dtack_n(dtack_a), .berr_n(berr_a),
        .rom_addr(raddr_a), .rom_dout(rom_dout_a));

    rom_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .LATENCY(L_B), .WAIT_STATES(W_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .cpu_addr(cpu_addr), .cpu_din(din_b), .dtack_n(dtack_b), .berr_n(berr_b),
        .rom_addr(raddr_b), .rom_dout(rom_dout_b));

    // ROM models: data is readable LATENCY cycles after the address edge
    assign rom_dout_a = rom_mem[raddr_a];
    always @(posedge clk) rom_pipe_b <= rom_mem[raddr_b];
    assign rom_dout_b = rom_pipe_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected bus response k edges after the start edge of a cycle whose
    // strobe is held low for h edges (start edge included).
    task automatic check_one(input string nm, input int d, input int k, input bit st,
                             input bit rd, input int h, input logic [15:0] word,
                             input logic [AW-1:0] a, input logic obs_dtack, input logic obs_berr,
                             input logic [15:0] obs_din, input logic [AW-1:0] obs_addr,
                             inout logic [15:0] e_din, inout logic [AW-1:0] e_addr);
        bit ack_lo, err_lo;
        ack_lo = 1'b0;
        err_lo = 1'b0;
        if (st && rd) begin
            if (k == 0) e_addr = a;
            if (k == d && d < h) e_din = word;
            ack_lo = (k >= d) && (k < h);
        end else if (st) begin
`ifdef ROM_BERR_EN
            err_lo = (k < h);
`else
            ack_lo = (k < h);
`endif
        end
        chk($sformatf("%s_dtack_k%0d", nm, k), 32'(obs_dtack), 32'(!ack_lo));
        chk($sformatf("%s_berr_k%0d", nm, k),  32'(obs_berr),  32'(!err_lo));
        chk($sformatf("%s_din_k%0d", nm, k),   32'(obs_din),   32'(e_din));
        chk($sformatf("%s_addr_k%0d", nm, k),  32'(obs_addr),  32'(e_addr));
    endtask

    task automatic run_txn(input bit c, input bit rd, input bit u, input bit l,
                           input logic [AW-1:0] a, input int h);
        bit st;
        logic [15:0] word;
        st   = c && (!u || !l);
        word = {u ? 8'h00 : rom_mem[a][15:8], l ? 8'h00 : rom_mem[a][7:0]};
        @(negedge clk);
        cs = c; as_n = 1'b0; rw = rd; uds_n = u; lds_n = l; cpu_addr = a;
        for (int k = 0; k <= h; k++) begin
            @(negedge clk);
            check_one("a", D_A, k, st, rd, h, word, a, dtack_a, berr_a, din_a, raddr_a, e_din_a, e_addr_a);
            check_one("b", D_B, k, st, rd, h, word, a, dtack_b, berr_b, din_b, raddr_b, e_din_b, e_addr_b);
            // Once a cycle is under way, cs must no longer matter
            if (st) cs = 1'($urandom);
            if (k == h - 1) as_n = 1'b1;
        end
        cs = 1'b0;
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_dtack_a"}, 32'(dtack_a), 32'h1);
        chk({nm, "_berr_a"},  32'(berr_a),  32'h1);
        chk({nm, "_din_a"},   32'(din_a),   32'h0);
        chk({nm, "_addr_a"},  32'(raddr_a), 32'h0);
        chk({nm, "_dtack_b"}, 32'(dtack_b), 32'h1);
        chk({nm, "_berr_b"},  32'(berr_b),  32'h1);
        chk({nm, "_din_b"},   32'(din_b),   32'h0);
        chk({nm, "_addr_b"},  32'(raddr_b), 32'h0);
    endtask

    initial begin
        int kind, lanes;
        bit u, l;
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'($urandom);
        rom_mem[14'h0123] = 16'hBEEF;
        rom_mem[14'h0010] = 16'hA55A;

        #1 rst_n = 1'b0;
        #1 check_reset_values("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: word read, byte lanes, boundary addresses
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h0123, 7);
        chk("beef_a", 32'(din_a), 32'hBEEF);
        chk("beef_b", 32'(din_b), 32'hBEEF);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 14'h0010, 7);
        chk("upper_lane_a", 32'(din_a), 32'hA500);
        run_txn(1'b1, 1'b1, 1'b1, 1'b0, 14'h0010, 7);
        chk("lower_lane_b", 32'(din_b), 32'h005A);
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h3FFF, 6);
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 6);
        // Abort the wait-state instance mid-WAIT, then read again
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h0123, 3);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 14'h0010, 6);
        // Writes never reach the ROM
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 14'h0123, 3);
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h0123, 6);
        chk("rom_after_write", 32'(din_b), 32'hBEEF);

        for (int t = 0; t < 80; t++) begin
            kind  = int'($urandom_range(0, 9));
            lanes = int'($urandom_range(0, 2));
            u = (lanes == 2);
            l = (lanes == 1);
            if (kind == 1) begin
                u = 1'b1;
                l = 1'b1;
            end
            run_txn(kind != 0, kind >= 4, u, l, AW'($urandom_range(0, (1 << AW) - 1)),
                    int'($urandom_range(1, 8)));
        end

        // Asynchronous reset while the wait-state instance is in WAIT
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; cpu_addr = 14'h0123;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid_wait");
        e_din_a = '0; e_din_b = '0; e_addr_a = '0; e_addr_b = '0;
        @(negedge clk);
        as_n = 1'b1; cs = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 14'h0010, 7);
        chk("post_reset_read", 32'(din_b), 32'hA55A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_bus_bridge.md
Name: rom_bus_bridge

Overview:
- 68000-side bus slave for the synchronous program ROM.
- Converts a CPU read cycle into a registered ROM address, waits out the ROM read latency plus optional wait states, then latches the word and returns it with DTACK.
- Sits between the CPU address decoder/bus and the ROM. The ROM is the downstream stage: it is addressed by this block, and its data output feeds back into this block.
- CPU bus signals are in the clk domain. The CPU core runs from clk with clock enables, so no synchronisers are required.

Parameters:
- ADDR_WIDTH, 14: word-address width of the ROM (16384 words).
- DATA_WIDTH, 16: ROM and CPU data width; must be 16.
- LATENCY, 1: cycles from rom_addr change to valid rom_dout; range 1..4.
- WAIT_STATES, 0: extra cycles inserted before DTACK; range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- cs  in  1  decoded ROM select from the address decoder, active-high
- as_n  in  1  CPU address strobe, active-low
- rw  in  1  CPU read (1) / write (0)
- uds_n  in  1  upper data strobe, active-low
- lds_n  in  1  lower data strobe, active-low
- cpu_addr  in  ADDR_WIDTH  CPU word address (A[ADDR_WIDTH:1])
- cpu_din  out  16  read data to the CPU
- dtack_n  out  1  data acknowledge, active-low
- berr_n  out  1  bus error, active-low
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_dout  in  16  ROM read data

Behaviour:
- Reset state:
  - state=IDLE
  - dtack_n=1, berr_n=1
  - cpu_din=0, rom_addr=0
  - wait counter=0
- FSM states: IDLE, WAIT, ACK, ERR. All outputs are registered.
- IDLE:
  - Start condition is cs & ~as_n & (~uds_n | ~lds_n).
  - Start with rw=1 (read): rom_addr<=cpu_addr; cnt<=LATENCY+WAIT_STATES; go to WAIT.
  - Start with rw=0 (write): go to ACK without touching ROM (write ignored); see ROM_BERR_EN.
  - Otherwise stay in IDLE.
- WAIT:
  - Each cycle cnt<=cnt-1.
  - At the cycle where cnt==1, latch cpu_din. Upper byte is rom_dout[15:8] if ~uds_n, else 0. Lower byte is rom_dout[7:0] if ~lds_n, else 0.
  - Then dtack_n<=0 and go to ACK.
- ACK:
  - Hold dtack_n=0 and cpu_din stable.
  - When as_n==1: dtack_n<=1, go to IDLE. cpu_din keeps its value.
- Timing with start sampled at edge N:
  - rom_addr is valid after edge N.
  - rom_dout is valid after N+LATENCY.
  - cpu_din is captured at edge N+LATENCY+WAIT_STATES and dtack_n falls at the same edge.
  - Defaults (LATENCY=1, WAIT_STATES=0): dtack_n is low one cycle after the start edge.
- Abort: as_n rising while in WAIT returns to IDLE next edge. No DTACK is issued; cpu_din is unchanged.
- Back-to-back cycles: a new start is only recognised in IDLE. Therefore at least one idle cycle with as_n=1 separates cycles.
- cs low while as_n is low has no effect outside IDLE. Cycle termination depends only on as_n.
- Counter width is 4 bits. The sum LATENCY+WAIT_STATES is at most 11, so no wrap.
- Asynchronous reset mid-cycle forces IDLE with dtack_n=1 immediately, regardless of clk.

Optional Feature:
- Macro: ROM_BERR_EN.
- With the macro defined, a write start (rw=0) goes to ERR: berr_n<=0, dtack_n stays 1. ERR holds until as_n==1, then berr_n<=1 and the FSM returns to IDLE.
- Without the macro, berr_n is tied to 1 and a write is acknowledged via ACK with cpu_din unchanged.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - FSM state typedef (IDLE/WAIT/ACK/ERR, 2 bits)
  - byte-lane select constants
  - active-low bus level constants, shared with the RAM and I/O bridges
- No sub-module. A single FSM plus counter is natural.

Test Plan:
1. Reset: assert rst_n=0 mid-WAIT -> dtack_n=1, berr_n=1, cpu_din=0, rom_addr=0 without a clock edge.
2. Word read, defaults: ROM[0x0123]=0xBEEF; cs=1, as_n=0, rw=1, uds_n=lds_n=0, cpu_addr=0x0123 -> rom_addr=0x0123 after 1 edge; dtack_n=0 with cpu_din=0xBEEF 1 cycle after start edge; dtack_n=1 one edge after as_n=1.
3. Byte lanes: ROM[0x10]=0xA55A; uds_n=0, lds_n=1 -> cpu_din=0xA500; uds_n=1, lds_n=0 -> cpu_din=0x005A.
4. Wait states: LATENCY=2, WAIT_STATES=3 -> dtack_n falls exactly 5 cycles after the start edge, with correct data.
5. Abort: as_n rises during WAIT (WAIT_STATES=3) -> dtack_n never asserted; next read returns correct data.
6. Write: rw=0 -> without ROM_BERR_EN, dtack_n=0 and ROM contents unchanged; with ROM_BERR_EN, berr_n=0, dtack_n=1, released after as_n=1.
